strobe_sync: RTL and testbench

STROBE_SYNC -- requirements
Module: strobe_sync

---
 rtl/strobe_sync_pkg.sv | 25 ++
 rtl/strobe_sync_period_meas.sv | 63 ++++++
 rtl/strobe_sync.sv | 162 ++++++++++++++++
 tb/tb_strobe_sync.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/strobe_sync_pkg.sv
// strobe_sync shared types: FSM encoding and width helpers
// derived from the period and tolerance parameters.
package strobe_sync_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCK   = 2'd2,
    HOLD   = 2'd3
  } state_t;

  function automatic int phase_w(input int num);
    return $clog2(num);
  endfunction

  function automatic int period_w(input int num, input int tol);
    return $clog2(num + tol + 1);
  endfunction

  // Elapsed counter must also hold the saturation value NUM+TOL+1.
  function automatic int elapsed_w(input int num, input int tol);
    return $clog2(num + tol + 2);
  endfunction

endpackage

// File: rtl/strobe_sync_period_meas.sv
// Elapsed-cycle counter since the reference strobe, with window
// saturation, flywheel advance and the good/bad period compare.
module strobe_sync_period_meas
  import strobe_sync_pkg::*;
#(
  parameter int NUM = 2048,
  parameter int TOL = 2
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_ref,
  input  logic                         i_fly_en,
  input  logic                         i_upd,
  output logic                         o_good,
  output logic                         o_close,
  output logic [period_w(NUM,TOL)-1:0] o_period
);

  localparam int EW = elapsed_w(NUM, TOL);
  localparam int QW = period_w(NUM, TOL);

  localparam logic [EW-1:0] C_ONE  = EW'(1);
  localparam logic [EW-1:0] C_LO   = EW'(NUM - TOL);
  localparam logic [EW-1:0] C_HI   = EW'(NUM + TOL);
  localparam logic [EW-1:0] C_MAX  = EW'(NUM + TOL + 1);
  localparam logic [EW-1:0] C_FLY  = EW'(TOL + 1);
  localparam logic [EW-1:0] C_QMAX = EW'((1 << QW) - 1);

  logic [EW-1:0] r_elapsed;
  logic [EW-1:0] w_p;
  logic [EW-1:0] w_next;
  logic          w_close;
  logic          w_fly;

  assign w_close = (r_elapsed == C_MAX);
  assign w_fly   = w_close && i_fly_en;

  // On a flywheel step the reference moves NUM forward, so a
  // strobe in that same cycle is measured against the new one.
  assign w_p = w_fly ? C_FLY : r_elapsed;

  assign o_good  = (w_p >= C_LO) && (w_p <= C_HI);
  assign o_close = w_close;

  always_comb begin
    w_next = r_elapsed + C_ONE;
    if (i_ref)        w_next = C_ONE;
    else if (w_fly)   w_next = C_FLY + C_ONE;
    else if (w_close) w_next = C_MAX;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_elapsed <= '0;
      o_period  <= '0;
    end else begin
      r_elapsed <= w_next;
      if (i_upd)
        o_period <= (w_p > C_QMAX) ? QW'(C_QMAX) : QW'(w_p);
    end
  end

endmodule

// File: rtl/strobe_sync.sv
// strobe_sync: locks to a periodic strobe and regenerates it,
// riding through missed strobes with a flywheel.
module strobe_sync
  import strobe_sync_pkg::*;
#(
  parameter int NUM      = 2048,
  parameter int TOL      = 2,
  parameter int LOCK_CNT = 3,
  parameter int MISS_MAX = 2
) (
  input  logic                         clk_sig,
  input  logic                         reset_sig,
  input  logic                         strobe_sig,
  output logic                         locked_sig,
  output logic                         tick_sig,
  output logic [phase_w(NUM)-1:0]      phase_sig,
  output logic [period_w(NUM,TOL)-1:0] period_sig,
  output logic                         err_sig
);

  localparam int PW = phase_w(NUM);
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int MW = $clog2(MISS_MAX + 1);

  localparam logic [PW-1:0] C_PH_LAST = PW'(NUM - 1);
  localparam logic [GW-1:0] C_GOOD    = GW'(LOCK_CNT);
  localparam logic [MW-1:0] C_MISS    = MW'(MISS_MAX);

  if (NUM < 4 || 2 * TOL >= NUM || LOCK_CNT < 1 || MISS_MAX < 1)
  begin : g_bad_param
    $error("strobe_sync: illegal parameter set");
  end

  logic [1:0]    r_rst_sync;
  logic          w_rst_n;
  state_t        r_state;
  state_t        w_state_d;
  logic [GW-1:0] r_good;
  logic [GW-1:0] w_good_d;
  logic [MW-1:0] r_miss;
  logic [MW-1:0] w_miss_d;
  logic          w_ref;
  logic          w_realign;
  logic          w_upd;
  logic          w_err_d;
  logic          w_fly_en;
  logic          w_good;
  logic          w_close;
  logic          w_locked_d;
  logic          w_tick_d;
  logic [PW-1:0] w_phase_d;

  // Assert asynchronously, release on the second clock edge.
  always_ff @(posedge clk_sig or negedge reset_sig) begin
    if (!reset_sig) r_rst_sync <= '0;
    else            r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n  = r_rst_sync[1];
  assign w_fly_en = (r_state == LOCK) || (r_state == HOLD);

  strobe_sync_period_meas #(
    .NUM (NUM),
    .TOL (TOL)
  ) u_meas (
    .i_clk    (clk_sig),
    .i_rst_n  (w_rst_n),
    .i_ref    (w_ref),
    .i_fly_en (w_fly_en),
    .i_upd    (w_upd),
    .o_good   (w_good),
    .o_close  (w_close),
    .o_period (period_sig)
  );

  always_ff @(posedge clk_sig or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state    <= SEARCH;
      r_good     <= '0;
      r_miss     <= '0;
      locked_sig <= 1'b0;
      tick_sig   <= 1'b0;
      phase_sig  <= '0;
      err_sig    <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_good     <= w_good_d;
      r_miss     <= w_miss_d;
      locked_sig <= w_locked_d;
      tick_sig   <= w_tick_d;
      phase_sig  <= w_phase_d;
      err_sig    <= w_err_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_good_d  = r_good;
    w_miss_d  = r_miss;
    w_ref     = 1'b0;
    w_realign = 1'b0;
    w_upd     = 1'b0;
    w_err_d   = 1'b0;
    unique case (r_state)
      SEARCH: begin
        if (strobe_sig) begin
          w_ref     = 1'b1;
          w_good_d  = '0;
          w_miss_d  = '0;
          w_state_d = VERIFY;
        end
      end
      VERIFY: begin
        if (strobe_sig) begin
          w_upd = 1'b1;
          w_ref = 1'b1;
          if (w_good) begin
            w_good_d = r_good + GW'(1);
            if (w_good_d == C_GOOD) begin
              w_state_d = LOCK;
              w_realign = 1'b1;
              w_miss_d  = '0;
            end
          end else begin
            w_err_d  = 1'b1;
            w_good_d = '0;
          end
        end else if (w_close) begin
          w_state_d = SEARCH;
        end
      end
      LOCK, HOLD: begin
        if (w_close) begin
          w_miss_d  = r_miss + MW'(1);
          w_state_d = (w_miss_d == C_MISS) ? SEARCH : HOLD;
        end
        if (strobe_sig) begin
          w_upd = 1'b1;
          if (w_good) begin
            w_ref     = 1'b1;
            w_realign = 1'b1;
            w_miss_d  = '0;
            w_state_d = LOCK;
          end else begin
            w_err_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_comb begin
    w_locked_d = (w_state_d == LOCK) || (w_state_d == HOLD);
    w_tick_d   = 1'b0;
    w_phase_d  = '0;
    if (w_locked_d) begin
      if (w_realign || phase_sig == C_PH_LAST) w_tick_d = 1'b1;
      else w_phase_d = phase_sig + PW'(1);
    end
  end

endmodule

// File: tb/tb_strobe_sync.sv
// Directed bench for strobe_sync at NUM=16, TOL=1,
// LOCK_CNT=3, MISS_MAX=2.
module tb_strobe_sync;

  localparam int NUM      = 16;
  localparam int TOL      = 1;
  localparam int LOCK_CNT = 3;
  localparam int MISS_MAX = 2;
  localparam int NC       = 110;

  logic       clk_sig = 1'b0;
  logic       reset_sig;
  logic       strobe_sig;
  logic       locked_sig;
  logic       tick_sig;
  logic [3:0] phase_sig;
  logic [4:0] period_sig;
  logic       err_sig;

  int n_run  = 0;
  int n_fail = 0;

  bit         sq[NC];
  bit         tk[NC];
  bit         er[NC];
  bit         lk[NC];
  logic [3:0] ph[NC];
  logic [4:0] pr[NC];

  strobe_sync #(
    .NUM      (NUM),
    .TOL      (TOL),
    .LOCK_CNT (LOCK_CNT),
    .MISS_MAX (MISS_MAX)
  ) u_dut (
    .clk_sig    (clk_sig),
    .reset_sig  (reset_sig),
    .strobe_sig (strobe_sig),
    .locked_sig (locked_sig),
    .tick_sig   (tick_sig),
    .phase_sig  (phase_sig),
    .period_sig (period_sig),
    .err_sig    (err_sig)
  );

  always #5 clk_sig = ~clk_sig;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    strobe_sig = 1'b0;
    reset_sig  = 1'b0;
    repeat (2) @(posedge clk_sig);
    #1;
    check("rst_locked", 32'(locked_sig), 0);
    check("rst_tick", 32'(tick_sig), 0);
    check("rst_err", 32'(err_sig), 0);
    check("rst_phase", 32'(phase_sig), 0);
    check("rst_period", 32'(period_sig), 0);
    reset_sig = 1'b1;
    repeat (3) @(posedge clk_sig);
  endtask

  task automatic sched(input int a, input int b, input int c,
                       input int d, input int e, input int f);
    for (int i = 0; i < NC; i++) sq[i] = 1'b0;
    if (a >= 0) sq[a] = 1'b1;
    if (b >= 0) sq[b] = 1'b1;
    if (c >= 0) sq[c] = 1'b1;
    if (d >= 0) sq[d] = 1'b1;
    if (e >= 0) sq[e] = 1'b1;
    if (f >= 0) sq[f] = 1'b1;
  endtask

  // Cycle c is the interval after the c-th edge of the run.
  task automatic run(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk_sig);
      #1;
      tk[c] = tick_sig;
      er[c] = err_sig;
      lk[c] = locked_sig;
      ph[c] = phase_sig;
      pr[c] = period_sig;
      strobe_sig = sq[c];
    end
  endtask

  function automatic int n_err(input int n);
    int s = 0;
    for (int i = 0; i < n; i++) s += int'(er[i]);
    return s;
  endfunction

  function automatic int n_tick(input int n);
    int s = 0;
    for (int i = 0; i < n; i++) s += int'(tk[i]);
    return s;
  endfunction

  initial begin
    // Lock, flywheel, drop
    do_reset();
    sched(10, 26, 42, 58, -1, -1);
    run(100);
    check("A_lk58", 32'(lk[58]), 0);
    check("A_lk59", 32'(lk[59]), 1);
    check("A_tk59", 32'(tk[59]), 1);
    check("A_ph59", 32'(ph[59]), 0);
    check("A_ph60", 32'(ph[60]), 1);
    check("A_pr59", 32'(pr[59]), 16);
    check("A_tk75", 32'(tk[75]), 1);
    check("A_ph75", 32'(ph[75]), 0);
    check("A_lk77", 32'(lk[77]), 1);
    check("A_tk91", 32'(tk[91]), 1);
    check("A_lk92", 32'(lk[92]), 1);
    check("A_lk93", 32'(lk[93]), 0);
    check("A_ph95", 32'(ph[95]), 0);
    check("A_ntick", 32'(n_tick(100)), 3);
    check("A_nerr", 32'(n_err(100)), 0);

    // Jitter +17 then +15, both accepted
    do_reset();
    sched(10, 26, 42, 58, 75, 90);
    run(100);
    check("B_tk76", 32'(tk[76]), 1);
    check("B_pr76", 32'(pr[76]), 17);
    check("B_ph80", 32'(ph[80]), 4);
    check("B_tk91", 32'(tk[91]), 1);
    check("B_pr91", 32'(pr[91]), 15);
    check("B_lk99", 32'(lk[99]), 1);
    check("B_nerr", 32'(n_err(100)), 0);

    // Strobe one cycle past the window: miss, then bad
    do_reset();
    sched(10, 26, 42, 58, 76, -1);
    run(100);
    check("C_er77", 32'(er[77]), 1);
    check("C_pr77", 32'(pr[77]), 2);
    check("C_lk77", 32'(lk[77]), 1);
    check("C_tk91", 32'(tk[91]), 1);
    check("C_lk93", 32'(lk[93]), 0);
    check("C_nerr", 32'(n_err(100)), 1);

    // Bad period during verification
    do_reset();
    sched(10, 26, 38, 54, 70, 86);
    run(100);
    check("D_er39", 32'(er[39]), 1);
    check("D_pr39", 32'(pr[39]), 12);
    check("D_lk86", 32'(lk[86]), 0);
    check("D_lk87", 32'(lk[87]), 1);
    check("D_tk87", 32'(tk[87]), 1);
    check("D_nerr", 32'(n_err(100)), 1);

    // Asynchronous reset in the middle of lock
    do_reset();
    sched(10, 26, 42, 58, -1, -1);
    run(66);
    check("E_pre_lk", 32'(locked_sig), 1);
    check("E_pre_ph", 32'(phase_sig), 6);
    #3 reset_sig = 1'b0;
    #1;
    check("E_async_lk", 32'(locked_sig), 0);
    check("E_async_tk", 32'(tick_sig), 0);
    check("E_async_ph", 32'(phase_sig), 0);
    do_reset();
    sched(10, 26, 42, 58, -1, -1);
    run(62);
    check("E_lk43", 32'(lk[43]), 0);
    check("E_lk58", 32'(lk[58]), 0);
    check("E_lk59", 32'(lk[59]), 1);
    check("E_tk59", 32'(tk[59]), 1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
